pixel_xform: RTL and testbench

Parametrised, pipelined per-channel pixel transform for the video datapath. Accepts one NCH-channel pixel per beat on a valid/ready stream, applies a run-time selectable point operation (pass, invert, saturating add, threshold) to every channel, and presents the result on an output stream. The block sits between pixel sources and downstream filters, with full backpressure support.

---
 rtl/pixel_xform.sv | 112 +++++++++++
 tb/tb_pixel_xform.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_xform.sv
// Two-stage elastic pixel point-transform: stage 1 captures beat + config,
// stage 2 holds the per-channel result that drives the output stream.
module pixel_xform #(
  parameter int NCH = 3,
  parameter int DW  = 8,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    cfg_mode,
  input  logic [DW-1:0] cfg_k,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data [NCH-1:0],
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data [NCH-1:0],
  output logic          m_last,
  output logic [CW-1:0] beat_count
);

  localparam logic [1:0]    MODE_PASS = 2'd0;
  localparam logic [1:0]    MODE_INV  = 2'd1;
  localparam logic [1:0]    MODE_SAT  = 2'd2;
  localparam logic [DW-1:0] MAX       = {DW{1'b1}};

  logic          v1_q, v2_q;
  logic          last1_q, last2_q;
  logic [1:0]    mode1_q;
  logic [DW-1:0] k1_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          adv1, adv2;
  logic          load1, load2;

  // A stage may advance when empty or when the stage after it is moving.
  assign adv2    = !v2_q || m_ready;
  assign adv1    = !v1_q || adv2;
  assign s_ready = adv1;
  assign load1   = adv1 && s_valid;
  assign load2   = adv2 && v1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      last1_q <= 1'b0;
      mode1_q <= MODE_PASS;
      k1_q    <= '0;
      v2_q    <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= s_valid;
      if (load1) begin
        last1_q <= s_last;
        mode1_q <= cfg_mode;
        k1_q    <= cfg_k;
      end
      if (adv2) v2_q <= v1_q;
      if (load2) last2_q <= last1_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DW-1:0] d1_q, d2_q, res_d;
      logic [DW:0]   sum;

      // One extra bit keeps the carry so the add can clamp at MAX.
      assign sum = {1'b0, d1_q} + {1'b0, k1_q};

      always_comb begin
        res_d = d1_q;
        case (mode1_q)
          MODE_PASS: res_d = d1_q;
          MODE_INV:  res_d = MAX - d1_q;
          MODE_SAT:  res_d = sum[DW] ? MAX : sum[DW-1:0];
          default:   res_d = (d1_q >= k1_q) ? MAX : '0;
        endcase
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          d1_q <= '0;
          d2_q <= '0;
        end else begin
          if (load1) d1_q <= s_data[gi];
          if (load2) d2_q <= res_d;
        end
      end

      assign m_data[gi] = d2_q;
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    if (v2_q && m_ready) begin
      cnt_d = last2_q ? '0 : cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign m_valid    = v2_q;
  assign m_last     = last2_q;
  assign beat_count = cnt_q;

endmodule

// File: tb/tb_pixel_xform.sv
// Bench for pixel_xform: table vectors, hand-written corner sequences and a
// randomized backpressure stream scored against a plain-arithmetic model.
module tb_pixel_xform;

  localparam int NCH = 3;
  localparam int DW  = 8;
  localparam int CW  = 16;

  typedef struct packed {
    logic [1:0]       mode;
    logic [7:0]       k;
    logic [2:0][7:0]  x;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [2:0][7:0]  d;
    logic             last;
  } exp_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [7:0]       k;
    logic [2:0][7:0]  x;
    logic [2:0][7:0]  y;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    cfg_mode;
  logic [DW-1:0] cfg_k;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data [NCH-1:0];
  logic          s_last;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data [NCH-1:0];
  logic          m_last;
  logic [CW-1:0] beat_count;

  int checks = 0;
  int errors = 0;

  beat_t            in_q [$];
  exp_t             exp_q [$];
  logic [2:0][7:0]  out_d [$];
  logic [15:0]      out_cnt [$];
  logic [15:0]      model_cnt = 16'd0;

  pixel_xform #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_k(cfg_k),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Reference point operation written straight from the arithmetic rules.
  function automatic logic [7:0] ref_px(input logic [1:0] mode, input logic [7:0] k,
                                        input logic [7:0] x);
    int s;
    case (mode)
      2'd0:    return x;
      2'd1:    return 8'(255 - int'(x));
      2'd2: begin
        s = int'(x) + int'(k);
        return (s > 255) ? 8'd255 : 8'(s);
      end
      default: return (int'(x) >= int'(k)) ? 8'd255 : 8'd0;
    endcase
  endfunction

  task automatic drive_idle();
    s_valid  = 1'b0;
    cfg_mode = 'x;
    cfg_k    = 'x;
    s_last   = 1'bx;
    for (int c = 0; c < NCH; c++) s_data[c] = 'x;
  endtask

  task automatic drive_beat(input beat_t b);
    s_valid  = 1'b1;
    cfg_mode = b.mode;
    cfg_k    = b.k;
    s_last   = b.last;
    for (int c = 0; c < NCH; c++) s_data[c] = b.x[c];
  endtask

  // Streams in_q through the DUT with given valid/ready duty (percent).
  task automatic run_stream(input int vpct, input int rpct, input int budget);
    int cyc = 0;
    bit stall_prev = 1'b0;
    bit in_hs, out_hs, want_ready;
    logic [2:0][7:0] prev_d;
    logic prev_last;
    exp_t e;
    beat_t b;
    out_d.delete();
    out_cnt.delete();
    while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      check("mvalid_known", {31'b0, $isunknown(m_valid)}, 32'd0);
      if (stall_prev) begin
        check("stall_valid", {31'b0, m_valid}, 32'd1);
        check("stall_last", {31'b0, m_last}, {31'b0, prev_last});
        for (int c = 0; c < NCH; c++) check("stall_data", {24'b0, m_data[c]}, {24'b0, prev_d[c]});
      end
      m_ready = ($urandom_range(99) < rpct);
      if (in_q.size() > 0 && $urandom_range(99) < vpct) drive_beat(in_q[0]);
      else drive_idle();
      #1;
      want_ready = !(exp_q.size() == 2 && !m_ready);
      check("s_ready", {31'b0, s_ready}, {31'b0, want_ready});
      in_hs  = s_valid && s_ready;
      out_hs = m_valid && m_ready;
      if (out_hs) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          for (int c = 0; c < NCH; c++) check("m_data", {24'b0, m_data[c]}, {24'b0, e.d[c]});
          check("m_last", {31'b0, m_last}, {31'b0, e.last});
          model_cnt = e.last ? 16'd0 : model_cnt + 16'd1;
          for (int c = 0; c < NCH; c++) prev_d[c] = m_data[c];
          out_d.push_back(prev_d);
          $display("beat out data=%h %h %h last=%0b", m_data[2], m_data[1], m_data[0], m_last);
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_last  = m_last;
      for (int c = 0; c < NCH; c++) prev_d[c] = m_data[c];
      @(posedge clk);
      if (in_hs) begin
        b = in_q.pop_front();
        for (int c = 0; c < NCH; c++) e.d[c] = ref_px(b.mode, b.k, b.x[c]);
        e.last = b.last;
        exp_q.push_back(e);
      end
      #1;
      check("beat_count", {16'b0, beat_count}, {16'b0, model_cnt});
      if (out_hs) out_cnt.push_back(beat_count);
      cyc++;
    end
    check("stream_done", in_q.size() + exp_q.size(), 32'd0);
    in_q.delete();
    exp_q.delete();
    @(negedge clk);
    drive_idle();
  endtask

  vec_t vecs [4];
  logic [7:0] mc_exp [4];
  logic [15:0] cnt_exp [5];
  beat_t b;

  initial begin
    drive_idle();
    vecs[0] = '{mode: 2'd0, k: 8'h00, x: {8'h56, 8'h34, 8'h12}, y: {8'h56, 8'h34, 8'h12}};
    vecs[1] = '{mode: 2'd1, k: 8'h00, x: {8'hFF, 8'h7F, 8'h00}, y: {8'h00, 8'h80, 8'hFF}};
    vecs[2] = '{mode: 2'd2, k: 8'h40, x: {8'h10, 8'hBF, 8'hC0}, y: {8'h50, 8'hFF, 8'hFF}};
    vecs[3] = '{mode: 2'd3, k: 8'h80, x: {8'hFF, 8'h80, 8'h7F}, y: {8'hFF, 8'hFF, 8'h00}};
    mc_exp[0] = 8'h20; mc_exp[1] = 8'hDF; mc_exp[2] = 8'h30; mc_exp[3] = 8'hFF;
    cnt_exp[0] = 16'd1; cnt_exp[1] = 16'd2; cnt_exp[2] = 16'd3; cnt_exp[3] = 16'd4; cnt_exp[4] = 16'd0;

    // Outputs held at zero while reset is asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_last", {31'b0, m_last}, 32'd0);
    check("rst_beat_count", {16'b0, beat_count}, 32'd0);
    for (int c = 0; c < NCH; c++) check("rst_m_data", {24'b0, m_data[c]}, 32'd0);
    rst = 1'b0;
    #1 check("rst_s_ready", {31'b0, s_ready}, 32'd1);

    // Pass-through latency: visible after the second edge counting acceptance.
    @(negedge clk);
    m_ready = 1'b1;
    drive_beat('{mode: 2'd0, k: 8'h00, x: {8'h56, 8'h34, 8'h12}, last: 1'b1});
    @(posedge clk); #1;
    drive_idle();
    check("lat_valid_e1", {31'b0, m_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid_e2", {31'b0, m_valid}, 32'd1);
    check("lat_last", {31'b0, m_last}, 32'd1);
    check("lat_d0", {24'b0, m_data[0]}, 32'h12);
    check("lat_d1", {24'b0, m_data[1]}, 32'h34);
    check("lat_d2", {24'b0, m_data[2]}, 32'h56);
    @(posedge clk); #1;
    check("lat_drained", {31'b0, m_valid}, 32'd0);
    check("lat_count", {16'b0, beat_count}, 32'd0);
    model_cnt = 16'd0;

    // Table-driven single-beat vectors.
    for (int i = 0; i < 4; i++) begin
      in_q.push_back('{mode: vecs[i].mode, k: vecs[i].k, x: vecs[i].x, last: 1'b0});
      run_stream(100, 100, 50);
      check("vec_count", out_d.size(), 32'd1);
      if (out_d.size() == 1)
        for (int c = 0; c < NCH; c++) check("vec_y", {24'b0, out_d[0][c]}, {24'b0, vecs[i].y[c]});
    end

    // Mode changes on consecutive beats.
    for (int i = 0; i < 4; i++)
      in_q.push_back('{mode: 2'(i), k: 8'h10, x: {8'h20, 8'h20, 8'h20}, last: 1'b0});
    run_stream(100, 100, 50);
    check("mc_count", out_d.size(), 32'd4);
    for (int i = 0; i < 4 && i < out_d.size(); i++)
      for (int c = 0; c < NCH; c++) check("mc_y", {24'b0, out_d[i][c]}, {24'b0, mc_exp[i]});

    // Random stream under 50% valid / 50% ready.
    for (int i = 0; i < 20; i++) begin
      b.mode = 2'($urandom_range(3));
      b.k    = 8'($urandom_range(255));
      for (int c = 0; c < NCH; c++) b.x[c] = 8'($urandom_range(255));
      b.last = ($urandom_range(7) == 0);
      in_q.push_back(b);
    end
    run_stream(50, 50, 2000);
    check("rand_count", out_d.size(), 32'd20);

    // Reset with two beats in flight.
    @(negedge clk);
    m_ready = 1'b0;
    drive_beat('{mode: 2'd0, k: 8'h00, x: {8'h03, 8'h02, 8'h01}, last: 1'b0});
    @(posedge clk);
    @(negedge clk);
    drive_beat('{mode: 2'd1, k: 8'h00, x: {8'h06, 8'h05, 8'h04}, last: 1'b0});
    @(posedge clk); #1;
    drive_idle();
    check("full_valid", {31'b0, m_valid}, 32'd1);
    check("full_s_ready", {31'b0, s_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    check("midrst_valid", {31'b0, m_valid}, 32'd0);
    check("midrst_count", {16'b0, beat_count}, 32'd0);
    for (int c = 0; c < NCH; c++) check("midrst_data", {24'b0, m_data[c]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    model_cnt = 16'd0;
    repeat (4) begin
      @(negedge clk);
      check("no_stale", {31'b0, m_valid}, 32'd0);
    end

    // Counter progression with s_last on the fifth beat.
    for (int i = 0; i < 5; i++)
      in_q.push_back('{mode: 2'd0, k: 8'h00, x: {8'(i), 8'(i), 8'(i)}, last: (i == 4)});
    run_stream(100, 100, 50);
    check("cnt_len", out_cnt.size(), 32'd5);
    for (int i = 0; i < 5 && i < out_cnt.size(); i++)
      check("cnt_seq", {16'b0, out_cnt[i]}, {16'b0, cnt_exp[i]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
